// File: rtl/gcd_host_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_host_driver_pkg
// Description : Shared types and constants for the GCD host driver and its
//               golden reference engine. Holds the controller state encoding,
//               the operand/result width, the status counter width and a
//               saturating increment helper.
// Revision    : 1.0  initial release
// ============================================================================
package gcd_host_driver_pkg;

  localparam int DATA_W = 8;  // operand / result width
  localparam int CNT_W  = 8;  // run / error counter width

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RESET_PROC = 4'd1,
    ST_SETUP      = 4'd2,
    ST_ENTER_X    = 4'd3,
    ST_GAP        = 4'd4,
    ST_ENTER_Y    = 4'd5,
    ST_WAIT_HALT  = 4'd6,
    ST_CHECK      = 4'd7,
    ST_DONE       = 4'd8
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_golden.sv
`default_nettype none
// ============================================================================
// Module      : gcd_golden
// Description : Subtractive GCD reference engine. On load the operands are
//               captured; each following cycle the larger operand is replaced
//               by the difference until both are equal.
// Ports       : clock        - system clock
//               reset        - asynchronous active-low reset
//               load         - capture a/b and restart the computation
//               a, b         - operands (must be non-zero to terminate)
//               value        - current result (valid when golden_done)
//               golden_done  - operands equal, value is the GCD
// Revision    : 1.0  initial release
// ============================================================================
module gcd_golden
  import gcd_host_driver_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] value,
  output logic              golden_done
);

  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = a;
      y_d = b;
    end else if (x_q > y_q) begin
      x_d = x_q - y_q;
    end else if (y_q > x_q) begin
      y_d = y_q - x_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign value = x_q;
  // A load in flight means the registers still hold the previous pair.
  assign golden_done = (x_q == y_q) && !load;

endmodule
`default_nettype wire

// File: rtl/gcd_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : gcd_host_driver
// Description : Hardware host for the Processor operand handshake. On start it
//               resets the Processor, strobes X then Y onto Minput, waits for
//               Halt, captures Moutput and compares it with a locally computed
//               GCD. Keeps saturating run and error counters.
// Ports       : clock, reset(active-low async)
//               start, X, Y           - run request and operands
//               Halt, Moutput         - Processor status / result
//               proc_reset, Enter, Minput - Processor control (registered)
//               busy, done, result, expected, mismatch, timeout, invalid,
//               run_count, error_count - run status (registered)
// Revision    : 1.0  initial release
// ============================================================================
module gcd_host_driver
  import gcd_host_driver_pkg::*;
#(
  parameter int SETUP_CYCLES   = 4,
  parameter int GAP_CYCLES     = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic              Halt,
  input  logic [DATA_W-1:0] Moutput,
  output logic              proc_reset,
  output logic              Enter,
  output logic [DATA_W-1:0] Minput,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] expected,
  output logic              mismatch,
  output logic              timeout,
  output logic              invalid,
  output logic [CNT_W-1:0]  run_count,
  output logic [CNT_W-1:0]  error_count
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST   = WAIT_W'(SETUP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST     = WAIT_W'(GAP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic              proc_reset_q, proc_reset_d;
  logic              enter_q, enter_d;
  logic [DATA_W-1:0] minput_q, minput_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              mismatch_q, mismatch_d;
  logic              timeout_q, timeout_d;
  logic              invalid_q, invalid_d;
  logic [CNT_W-1:0]  run_count_q, run_count_d;
  logic [CNT_W-1:0]  error_count_q, error_count_d;

  logic              golden_load;
  logic [DATA_W-1:0] golden_value;
  logic              golden_done;

  gcd_golden u_golden (
    .clock       (clock),
    .reset       (reset),
    .load        (golden_load),
    .a           (X),
    .b           (Y),
    .value       (golden_value),
    .golden_done (golden_done)
  );

  // Next-state and next-output logic. Every output flop is loaded with the
  // value belonging to the state being entered, so outputs line up with
  // state_q without a combinational path to the pins.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    x_d           = x_q;
    y_d           = y_q;
    proc_reset_d  = 1'b1;
    enter_d       = 1'b0;
    minput_d      = minput_q;
    done_d        = 1'b0;
    result_d      = result_q;
    expected_d    = expected_q;
    mismatch_d    = mismatch_q;
    timeout_d     = timeout_q;
    invalid_d     = invalid_q;
    run_count_d   = run_count_q;
    error_count_d = error_count_q;
    golden_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d   = '0;
          expected_d = '0;
          timeout_d  = 1'b0;
          if ((X != '0) && (Y != '0)) begin
            x_d          = X;
            y_d          = Y;
            golden_load  = 1'b1;
            run_count_d  = sat_inc(run_count_q);
            mismatch_d   = 1'b0;
            invalid_d    = 1'b0;
            proc_reset_d = 1'b0;
            state_d      = ST_RESET_PROC;
          end else begin
            // Zero operand would never terminate the subtractive GCD.
            invalid_d     = 1'b1;
            mismatch_d    = 1'b1;
            error_count_d = sat_inc(error_count_q);
            done_d        = 1'b1;
          end
        end
      end
      ST_RESET_PROC: begin
        wait_d  = '0;
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (wait_q == SETUP_LAST) begin
          enter_d  = 1'b1;
          minput_d = x_q;
          state_d  = ST_ENTER_X;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ENTER_X: begin
        wait_d  = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (wait_q == GAP_LAST) begin
          enter_d  = 1'b1;
          minput_d = y_q;
          state_d  = ST_ENTER_Y;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ENTER_Y: begin
        wait_d  = '0;
        state_d = ST_WAIT_HALT;
      end
      ST_WAIT_HALT: begin
        if (Halt) begin
          result_d = Moutput;
          state_d  = ST_CHECK;
        end else if (wait_q == TIMEOUT_LAST) begin
          timeout_d     = 1'b1;
          mismatch_d    = 1'b1;
          error_count_d = sat_inc(error_count_q);
          done_d        = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        if (golden_done) begin
          expected_d = golden_value;
          mismatch_d = (result_q != golden_value);
          if (result_q != golden_value) begin
            error_count_d = sat_inc(error_count_q);
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      proc_reset_q  <= 1'b1;
      enter_q       <= 1'b0;
      minput_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      expected_q    <= '0;
      mismatch_q    <= 1'b0;
      timeout_q     <= 1'b0;
      invalid_q     <= 1'b0;
      run_count_q   <= '0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      x_q           <= x_d;
      y_q           <= y_d;
      proc_reset_q  <= proc_reset_d;
      enter_q       <= enter_d;
      minput_q      <= minput_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      expected_q    <= expected_d;
      mismatch_q    <= mismatch_d;
      timeout_q     <= timeout_d;
      invalid_q     <= invalid_d;
      run_count_q   <= run_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign proc_reset  = proc_reset_q;
  assign Enter       = enter_q;
  assign Minput      = minput_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign expected    = expected_q;
  assign mismatch    = mismatch_q;
  assign timeout     = timeout_q;
  assign invalid     = invalid_q;
  assign run_count   = run_count_q;
  assign error_count = error_count_q;

endmodule
`default_nettype wire
